smart_home_zoned: RTL

Parametrised multi-zone successor to the single-zone Smart_Home controller. It runs one heating/cooling thermostat state machine per zone, with hysteresis, a minimum on-time (anti-short-cycle) and sensor-fault detection. A single push button cycles which zone is shown on the shared 3-bit status colour output. The block sits between the zone temperature sensors and the HVAC drive and indicator logic.

---
 rtl/smart_home_zoned.sv | 77 +++++++
 1 files changed

// File: rtl/smart_home_zoned.sv
// smart_home_zoned: per-zone thermostat FSMs with hysteresis, minimum on-time, fault detect and button-selected status colour
module smart_home_zoned #(
  parameter int ZONES = 4,
  parameter int TEMP_W = 5,
  parameter int HEAT_ON = 18,
  parameter int TARGET = 20,
  parameter int COOL_ON = 22,
  parameter int MIN_DWELL = 8,
  localparam int SW = ZONES > 1 ? $clog2(ZONES) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    button,
  input  logic [ZONES*TEMP_W-1:0] temperature,
  output logic [ZONES-1:0]        heating,
  output logic [ZONES-1:0]        cooling,
  output logic [ZONES-1:0]        fault,
  output logic [SW-1:0]           zone_sel,
  output logic [2:0]              colour
);
  typedef enum logic [1:0] {IDLE, HEAT, COOL, FAULT} state_t;
  localparam int CW = MIN_DWELL > 0 ? $clog2(MIN_DWELL + 1) : 1;
  localparam logic [TEMP_W-1:0] HT = TEMP_W'(HEAT_ON);
  localparam logic [TEMP_W-1:0] TG = TEMP_W'(TARGET);
  localparam logic [TEMP_W-1:0] CL = TEMP_W'(COOL_ON);
  localparam logic [CW-1:0] DW = CW'(MIN_DWELL);
  logic [2:0] col [ZONES];
  logic btn_q;
  for (genvar z = 0; z < ZONES; z++) begin : g_zone
    state_t st, nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [TEMP_W-1:0] t;
    logic bad, dw;
    assign t = temperature[z*TEMP_W +: TEMP_W];
    always_comb begin
      bad = t == '0 || t == '1;
      dw = cnt == DW;
      cnt_nx = '0;
      nx = IDLE;
      case (st)
        IDLE: nx = t <= HT ? HEAT : t >= CL ? COOL : IDLE;
        HEAT: begin
          nx = dw && t >= TG ? IDLE : HEAT;
          cnt_nx = dw ? cnt : cnt + CW'(1);
        end
        COOL: begin
          nx = dw && t <= TG ? IDLE : COOL;
          cnt_nx = dw ? cnt : cnt + CW'(1);
        end
        default: nx = IDLE;
      endcase
      if (bad) nx = FAULT;
    end
    always_ff @(posedge clk)
      if (rst) begin
        st <= IDLE;
        cnt <= '0;
      end else begin
        st <= nx;
        cnt <= cnt_nx;
      end
    assign heating[z] = st == HEAT;
    assign cooling[z] = st == COOL;
    assign fault[z] = st == FAULT;
    assign col[z] = st == HEAT ? 3'b100 : st == COOL ? 3'b001 : st == FAULT ? 3'b111 : 3'b010;
  end
  // history resets high so a button held through reset gives no advance
  always_ff @(posedge clk)
    if (rst) begin
      btn_q <= 1'b1;
      zone_sel <= '0;
    end else begin
      btn_q <= button;
      if (button && !btn_q) zone_sel <= zone_sel == SW'(ZONES - 1) ? '0 : zone_sel + SW'(1);
    end
  assign colour = col[zone_sel];
endmodule
